// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants and helpers for the 4-digit seven-segment scan path.
// Digit count and widths match those used by the decoder and segment encoder.
package seven_seg_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;
  localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [VALUE_W-1:0] value_t;
  typedef logic [NUM_DIGITS-1:0] dp_t;

  localparam sel_t LAST_SEL = sel_t'(NUM_DIGITS - 1);

  function automatic digit_t digit_of(input value_t v, input sel_t idx);
    return v[DIGIT_W*idx +: DIGIT_W];
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_scan_prescaler.sv
// Free-running divider: tick is high for one cycle out of every TICK_DIV.
// TICK_DIV=1 degenerates to a constant-high tick.
module scan_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Scans a 16-bit hex value across four digit slots; new values are accepted into
// a shadow register and only committed to the display at frame boundaries.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int TICK_DIV      = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic               value_valid,
  output logic               value_ready,
  output logic [SEL_W-1:0]   digit_sel,
  output logic [DIGIT_W-1:0] nibble,
  output logic               dp_out,
  output logic               blank,
  output logic               frame_done
);

  logic   tick;
  logic   shadow_full;
  value_t shadow_val;
  dp_t    shadow_dp;
  value_t display_reg;
  dp_t    dp_reg;

  logic   fb;
  logic   accept;
  logic   commit;
  sel_t   next_sel;
  value_t disp_next;
  dp_t    dp_next;

  // A digit is blank only if it and every digit above it are zero and its dp is off.
  function automatic logic blank_of(input value_t v, input dp_t dp, input sel_t idx);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && v[DIGIT_W*i +: DIGIT_W] != '0) begin
        upper_zero = 1'b0;
      end
    end
    return (BLANK_LEADING != 0) && (idx != '0) && upper_zero && !dp[idx];
  endfunction

  scan_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign value_ready = ~shadow_full;
  assign fb          = tick & (digit_sel == LAST_SEL);
  assign accept      = value_valid & ~shadow_full;
  // Commit needs the shadow full before this edge, so a same-cycle accept never bypasses.
  assign commit      = fb & shadow_full;
  assign next_sel    = digit_sel + 1'b1;
  assign disp_next   = commit ? shadow_val : display_reg;
  assign dp_next     = commit ? shadow_dp  : dp_reg;

  always_ff @(posedge clk) begin
    if (accept) begin
      shadow_val <= value_in;
      shadow_dp  <= dp_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_full <= 1'b0;
      display_reg <= '0;
      dp_reg      <= '0;
      digit_sel   <= '0;
      nibble      <= '0;
      dp_out      <= 1'b0;
      blank       <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= fb;
      if (accept) begin
        shadow_full <= 1'b1;
      end else if (commit) begin
        shadow_full <= 1'b0;
      end
      if (commit) begin
        display_reg <= shadow_val;
        dp_reg      <= shadow_dp;
      end
      // Slot outputs are registered alongside the index they belong to.
      if (tick) begin
        digit_sel <= next_sel;
        nibble    <= digit_of(disp_next, next_sel);
        dp_out    <= dp_next[next_sel];
        blank     <= blank_of(disp_next, dp_next, next_sel);
      end
    end
  end

endmodule
